// File: rtl/lcd_timing_gen_if.sv
// Timing-generator bus: run request in; counters, fetch strobes and panel timing out.
interface lcd_timing_gen_if #(
  parameter int CNT_W = 11
);
  logic             enable;
  logic             running;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             active;
  logic             line_start;
  logic             frame_start;
  logic [7:0]       frame_cnt;
  logic             lcd_de;
  logic             lcd_hsync;
  logic             lcd_vsync;

  modport master (
    input  enable,
    output running, x, y, active, line_start, frame_start, frame_cnt,
           lcd_de, lcd_hsync, lcd_vsync
  );

  modport slave (
    output enable,
    input  running, x, y, active, line_start, frame_start, frame_cnt,
           lcd_de, lcd_hsync, lcd_vsync
  );
endinterface

// File: rtl/lcd_timing_gen.sv
// Parametrised LCD/VGA timing generator: pixel/line counters, fetch strobes,
// and DE/HSYNC/VSYNC delayed to line up with the pixel-data pipeline.
module lcd_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int PIPE_DELAY = 3,
  parameter int CNT_W      = 11
) (
  input  logic             pixel_clk,
  input  logic             rst_n,
  lcd_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // {de, hsync, vsync} as seen while stopped
  localparam logic [2:0] TIM_IDLE = {1'b0, ~HS_POL, ~VS_POL};

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;

  logic             last_pix_s;
  logic             running_s, active_s, line_start_s, frame_start_s;
  logic             hsync_s, vsync_s;

  assign last_pix_s = (h_q == H_LAST) && (v_q == V_LAST);

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        h_d = {CNT_W{1'b0}};
        v_d = {CNT_W{1'b0}};
        if (bus.enable) state_d = ST_RUN;
        else            state_d = ST_IDLE;
      end
      ST_RUN, ST_DRAIN: begin
        if (h_q == H_LAST) begin
          h_d = {CNT_W{1'b0}};
          if (v_q == V_LAST) begin
            v_d         = {CNT_W{1'b0}};
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            v_d = v_q + CNT_W'(1);
          end
        end else begin
          h_d = h_q + CNT_W'(1);
        end
        // A stop request only takes effect on the last pixel of a frame
        if (bus.enable)                             state_d = ST_RUN;
        else if (state_q == ST_DRAIN && last_pix_s) state_d = ST_IDLE;
        else                                        state_d = ST_DRAIN;
      end
      default: begin
        state_d = ST_IDLE;
        h_d     = {CNT_W{1'b0}};
        v_d     = {CNT_W{1'b0}};
      end
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      h_q         <= {CNT_W{1'b0}};
      v_q         <= {CNT_W{1'b0}};
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  always_comb begin
    running_s     = (state_q != ST_IDLE);
    active_s      = running_s && (h_q < H_ACT_END) && (v_q < V_ACT_END);
    line_start_s  = running_s && (h_q == {CNT_W{1'b0}});
    frame_start_s = line_start_s && (v_q == {CNT_W{1'b0}});
    hsync_s       = (running_s && (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END)) ? HS_POL : ~HS_POL;
    vsync_s       = (running_s && (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END)) ? VS_POL : ~VS_POL;
  end

  assign bus.running     = running_s;
  assign bus.x           = h_q;
  assign bus.y           = v_q;
  assign bus.active      = active_s;
  assign bus.line_start  = line_start_s;
  assign bus.frame_start = frame_start_s;
  assign bus.frame_cnt   = frame_cnt_q;

  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign bus.lcd_de    = active_s;
      assign bus.lcd_hsync = hsync_s;
      assign bus.lcd_vsync = vsync_s;
    end else begin : g_delay
      logic [2:0] pipe_q [PIPE_DELAY];
      logic [2:0] pipe_d [PIPE_DELAY];

      always_comb begin
        pipe_d[0] = {active_s, hsync_s, vsync_s};
        for (int i = 1; i < PIPE_DELAY; i++) pipe_d[i] = pipe_q[i-1];
      end

      always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= TIM_IDLE;
        end else begin
          for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_d[i];
        end
      end

      assign {bus.lcd_de, bus.lcd_hsync, bus.lcd_vsync} = pipe_q[PIPE_DELAY-1];
    end
  endgenerate
endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Parametrised LCD/VGA timing generator that replaces the hard-coded 640x480 counter logic in the LCD top level.
- Produces the pixel coordinates (x/y), early active and start strobes for the pixel-fetch pipeline, and DE/HSYNC/VSYNC outputs.
- The DE/HSYNC/VSYNC outputs are delayed by PIPE_DELAY so they line up with pixel data after ROM/FIFO/output stages.
- Adds full porch/sync timing, sync polarity, run/stop control with clean frame-boundary stop, and a frame counter.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (cycles)
- H_SYNC, 96, hsync pulse width (cycles)
- H_BP, 48, horizontal back porch (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level
- VS_POL, 0, vsync asserted level
- PIPE_DELAY, 3, cycles of delay on lcd_de/lcd_hsync/lcd_vsync (0 allowed)
- CNT_W, 11, width of x/y counters; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- pixel_clk  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request; 1 = generate frames
- running  out  1  1 while state is RUN or DRAIN
- x  out  CNT_W  horizontal counter h
- y  out  CNT_W  vertical counter v
- active  out  1  undelayed visible-area flag
- line_start  out  1  undelayed; 1 when h==0 while running
- frame_start  out  1  undelayed; 1 when h==0 and v==0 while running
- frame_cnt  out  8  completed-frame count, wraps 255->0
- lcd_de  out  1  active delayed by PIPE_DELAY
- lcd_hsync  out  1  hsync delayed by PIPE_DELAY
- lcd_vsync  out  1  vsync delayed by PIPE_DELAY

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Line order: active, FP, sync, BP. Frame order is the same.
- Reset: state IDLE; h=v=0; frame_cnt=0; running/active/line_start/frame_start/lcd_de=0; lcd_hsync=!HS_POL; lcd_vsync=!VS_POL; all delay-line stages hold these inactive values.
- States:
  - IDLE: h=v=0 held. enable=1 -> RUN; h stays 0 on that edge, so the first running cycle shows h=0, v=0.
  - RUN: h increments every cycle. At h==H_TOTAL-1, h->0 and v increments. At v==V_TOTAL-1, v->0 and frame_cnt increments.
    - enable=0 sampled -> DRAIN; counting continues unchanged.
  - DRAIN: counts as RUN.
    - enable=1 -> RUN, with no gap and no counter disturbance.
    - At the last pixel (h==H_TOTAL-1, v==V_TOTAL-1) with enable=0 -> IDLE, counters 0, frame_cnt increments.
    - If enable=1 on that same cycle -> RUN, continuing to (0,0).
- Undelayed outputs are combinational from the registered state/counters. All are forced 0 in IDLE.
  - active = running && h<H_ACTIVE && v<V_ACTIVE.
- Sync (pre-delay):
  - hsync asserted (HS_POL) when running && H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted (VS_POL) when running && V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for whole lines.
  - Deasserted level otherwise, including IDLE.
- Delay line: {active, hsync, vsync} pass through PIPE_DELAY registered stages. With PIPE_DELAY=0, lcd_* equal the undelayed values combinationally.
  - After stop, the delay line flushes inactive values.
- Reset mid-frame: immediate return to reset values, asynchronously. After rst_n deasserts, a new frame starts from (0,0) once enable is seen.
- No output glitches on RUN<->DRAIN transitions.

Test Plan:
- Default params, enable=1 from reset.
  - First running cycle: x=0, y=0, frame_start=1.
  - lcd_de rises exactly 3 cycles after active rises.
  - active high for 640 cycles per line on 480 lines; 420000 cycles per frame; frame_cnt=1 after the first frame.
- Default params, line 0: lcd_hsync low for h=656..751 (96 cycles), delayed by 3. lcd_vsync low throughout lines 490..491 only.
- Small config (H 4/1/1/1, V 3/1/1/1, PIPE_DELAY=0, HS_POL=1):
  - H_TOTAL=7, V_TOTAL=6, 42 cycles/frame.
  - hsync=1 only at h=5; lcd_de equals active in the same cycle.
- enable dropped at x=2,y=1 (small config):
  - running stays 1 until after (6,5), then x=y=0, running=0.
  - frame_cnt incremented once; lcd_de=0 thereafter.
- enable dropped then re-raised within the same frame (DRAIN->RUN): counter sequence continuous, no extra frame_start, running never 0.
- rst_n pulsed low mid-active: all outputs at reset values during reset without waiting for a clock; restart from (0,0) with frame_cnt=0.
